// File: rtl/display_source_arbiter.sv
// Shares one 3-digit 7-segment display among NUM_SRC requesters: round-robin
// rotation with a fixed dwell period, plus urgent pre-emption with a minimum hold.
module display_source_arbiter #(
  parameter int NUM_SRC           = 4,
  parameter int DWELL_CYCLES      = 100000000,
  parameter int URGENT_MIN_CYCLES = 50000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [NUM_SRC-1:0]     src_urgent,
  input  logic [13*NUM_SRC-1:0]  src_data,
  output logic [12:0]            hex_byte,
  output logic [2:0]             active_src,
  output logic                   display_blank,
  output logic [NUM_SRC-1:0]     src_shown
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int HW = (URGENT_MIN_CYCLES > 1) ? $clog2(URGENT_MIN_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHOW = 2'd1, ST_URGENT = 2'd2} state_t;
  typedef enum logic [1:0] {ACT_STAY = 2'd0, ACT_URGENT = 2'd1, ACT_NORMAL = 2'd2, ACT_IDLE = 2'd3} act_t;

  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
    logic [IW-1:0] r;
    if (idx == IW'(NUM_SRC-1)) r = '0;
    else                       r = idx + IW'(1);
    return r;
  endfunction

  // First set bit of v searching upward from start, wrapping; descending scan so the nearest wins.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_SRC-1:0] v, input logic [IW-1:0] start);
    logic [IW:0]   idx;
    logic [IW-1:0] r;
    r = '0;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      idx = {1'b0, start} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_SRC)) idx = idx - (IW+1)'(NUM_SRC);
      else                         idx = idx;
      if (v[idx[IW-1:0]]) r = idx[IW-1:0];
      else                r = r;
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] low_pick(input logic [NUM_SRC-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      if (v[k]) r = IW'(k);
      else      r = r;
    end
    return r;
  endfunction

  state_t            state_r, state_nxt_s;
  act_t              act_s;
  logic [IW-1:0]     owner_r, owner_nxt_s, rr_ptr_r, rr_nxt_s;
  logic [IW-1:0]     urg_idx_s, pick_s, pick_start_s;
  logic [DW-1:0]     dwell_r, dwell_nxt_s, dwell_fin_s;
  logic [HW-1:0]     hold_r, hold_nxt_s, hold_fin_s;
  logic [NUM_SRC-1:0] urg_s;
  logic              owner_valid_s, owner_urg_s, dwell_done_s, hold_done_s, grant_s;

  assign urg_s         = src_valid & src_urgent;
  assign urg_idx_s     = low_pick(urg_s);
  assign owner_valid_s = src_valid[owner_r];
  assign owner_urg_s   = urg_s[owner_r];
  assign dwell_done_s  = (dwell_r == DW'(DWELL_CYCLES-1));
  assign hold_done_s   = (hold_r == HW'(URGENT_MIN_CYCLES-1));
  assign pick_s        = rr_pick(src_valid, pick_start_s);

  // Decide what happens at the next edge; urgent requests outrank dwell expiry.
  always_comb begin
    act_s        = ACT_STAY;
    pick_start_s = rr_ptr_r;
    dwell_nxt_s  = dwell_r;
    hold_nxt_s   = hold_r;
    case (state_r)
      ST_IDLE: begin
        if (|urg_s)          act_s = ACT_URGENT;
        else if (|src_valid) act_s = ACT_NORMAL;
        else                 act_s = ACT_STAY;
      end
      ST_SHOW: begin
        pick_start_s = idx_inc(owner_r);
        if (|urg_s)              act_s = ACT_URGENT;
        else if (!owner_valid_s) act_s = (|src_valid) ? ACT_NORMAL : ACT_IDLE;
        else if (dwell_done_s)   act_s = ACT_NORMAL;
        else                     dwell_nxt_s = dwell_r + DW'(1);
      end
      ST_URGENT: begin
        if (!owner_valid_s) begin
          pick_start_s = idx_inc(owner_r);
          if (|urg_s)          act_s = ACT_URGENT;
          else if (|src_valid) act_s = ACT_NORMAL;
          else                 act_s = ACT_IDLE;
        end else if ((|urg_s) && (urg_idx_s < owner_r)) begin
          act_s = ACT_URGENT;
        end else if (owner_urg_s) begin
          hold_nxt_s = '0;
        end else if (hold_done_s) begin
          // Hold served: a waiting higher-index urgent goes next, otherwise resume rotation.
          act_s = (|urg_s) ? ACT_URGENT : ACT_NORMAL;
        end else begin
          hold_nxt_s = hold_r + HW'(1);
        end
      end
      default: act_s = ACT_IDLE;
    endcase
  end

  // Translate the chosen action into next-state values.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    rr_nxt_s    = rr_ptr_r;
    grant_s     = 1'b0;
    dwell_fin_s = dwell_nxt_s;
    hold_fin_s  = hold_nxt_s;
    case (act_s)
      ACT_URGENT: begin
        state_nxt_s = ST_URGENT;
        owner_nxt_s = urg_idx_s;
        grant_s     = 1'b1;
        dwell_fin_s = '0;
        hold_fin_s  = '0;
      end
      ACT_NORMAL: begin
        state_nxt_s = ST_SHOW;
        owner_nxt_s = pick_s;
        rr_nxt_s    = idx_inc(pick_s);
        grant_s     = 1'b1;
        dwell_fin_s = '0;
        hold_fin_s  = '0;
      end
      ACT_IDLE: begin
        state_nxt_s = ST_IDLE;
        owner_nxt_s = '0;
        dwell_fin_s = '0;
        hold_fin_s  = '0;
      end
      default: begin
        state_nxt_s = state_r;
      end
    endcase
  end

  // State registers and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      owner_r       <= '0;
      rr_ptr_r      <= '0;
      dwell_r       <= '0;
      hold_r        <= '0;
      hex_byte      <= 13'h0000;
      active_src    <= 3'd0;
      display_blank <= 1'b1;
      src_shown     <= '0;
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      rr_ptr_r <= rr_nxt_s;
      dwell_r  <= dwell_fin_s;
      hold_r   <= hold_fin_s;
      if (state_nxt_s == ST_IDLE) begin
        hex_byte      <= 13'h0000;
        active_src    <= 3'd0;
        display_blank <= 1'b1;
      end else begin
        hex_byte      <= src_data[13*int'(owner_nxt_s) +: 13];
        active_src    <= 3'(owner_nxt_s);
        display_blank <= 1'b0;
      end
      src_shown <= grant_s ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << owner_nxt_s) : '0;
    end
  end

endmodule

// File: tb/tb_display_source_arbiter.sv
// Self-checking bench for display_source_arbiter: directed scenarios plus random
// stimulus compared against a rule-level behavioural model.
module tb_display_source_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int UM = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_valid, src_urgent;
  logic [13*N-1:0] src_data;
  logic [12:0]     hex_byte;
  logic [2:0]      active_src;
  logic            display_blank;
  logic [N-1:0]    src_shown;

  int total = 0;
  int bad   = 0;

  // model state: mode 0 = idle, 1 = normal rotation, 2 = urgent
  int           m_mode, m_owner, m_rr, m_dwell, m_hold;
  logic [12:0]  exp_hex;
  logic [2:0]   exp_act;
  logic         exp_blank;
  logic [N-1:0] exp_shown;

  display_source_arbiter #(.NUM_SRC(N), .DWELL_CYCLES(DW), .URGENT_MIN_CYCLES(UM)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_urgent(src_urgent), .src_data(src_data),
    .hex_byte(hex_byte), .active_src(active_src), .display_blank(display_blank), .src_shown(src_shown)
  );

  always #5 clk = ~clk;

  function automatic int first_from(int start);
    for (int k = 0; k < N; k++) if (src_valid[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic int lowest_urgent();
    for (int i = 0; i < N; i++) if (src_valid[i] && src_urgent[i]) return i;
    return -1;
  endfunction

  task automatic m_grant(input int idx, input int urgent_path);
    m_owner = idx;
    m_mode  = urgent_path ? 2 : 1;
    m_dwell = 0;
    m_hold  = 0;
    exp_shown[idx] = 1'b1;
    if (!urgent_path) m_rr = (idx + 1) % N;
  endtask

  task automatic model_tick();
    int u, f;
    exp_shown = '0;
    u = lowest_urgent();
    if (rst) begin
      m_mode = 0; m_owner = 0; m_rr = 0; m_dwell = 0; m_hold = 0;
    end else begin
      case (m_mode)
        0: begin
          if (u >= 0) m_grant(u, 1);
          else begin
            f = first_from(m_rr);
            if (f >= 0) m_grant(f, 0);
          end
        end
        1: begin
          if (u >= 0) m_grant(u, 1);
          else if (!src_valid[m_owner] || m_dwell == DW - 1) begin
            f = first_from((m_owner + 1) % N);
            if (f >= 0) m_grant(f, 0); else m_mode = 0;
          end else m_dwell++;
        end
        default: begin
          if (!src_valid[m_owner]) begin
            if (u >= 0) m_grant(u, 1);
            else begin
              f = first_from((m_owner + 1) % N);
              if (f >= 0) m_grant(f, 0); else m_mode = 0;
            end
          end else if (u >= 0 && u < m_owner) m_grant(u, 1);
          else if (src_urgent[m_owner]) m_hold = 0;
          else if (m_hold == UM - 1) begin
            if (u >= 0) m_grant(u, 1); else m_grant(first_from(m_rr), 0);
          end else m_hold++;
        end
      endcase
    end
    exp_blank = (m_mode == 0);
    exp_act   = exp_blank ? 3'd0 : 3'(m_owner);
    exp_hex   = exp_blank ? 13'h0000 : src_data[13*m_owner +: 13];
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; src_valid = '0; src_urgent = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_a0_data();
    for (int i = 0; i < N; i++) src_data[13*i +: 13] = 13'h0A0 + 13'(i);
  endtask

  task automatic test_reset();
    rst = 1'b1; src_valid = '0; src_urgent = '0; src_data = '0;
    step();
    rst = 1'b0;
    total++;
    if (hex_byte !== 13'h0000 || display_blank !== 1'b1 || active_src !== 3'd0 || src_shown !== 4'b0000) begin
      bad++;
      $display("FAIL reset: got hex=%h act=%0d blank=%b shown=%b want hex=0000 act=0 blank=1 shown=0000",
               hex_byte, active_src, display_blank, src_shown);
    end
    step();
    total++;
    if ({hex_byte, active_src, display_blank, src_shown} !== {exp_hex, exp_act, exp_blank, exp_shown}) begin
      bad++;
      $display("FAIL reset_idle: got act=%0d blank=%b want act=%0d blank=%b", active_src, display_blank, exp_act, exp_blank);
    end
  endtask

  task automatic test_rotation();
    int grants = 0;
    do_reset();
    src_valid = 4'b1111;
    load_a0_data();
    for (int s = 0; s < 20; s++) begin
      step();
      total++;
      if ({hex_byte, active_src, display_blank, src_shown} !== {exp_hex, exp_act, exp_blank, exp_shown}) begin
        bad++;
        $display("FAIL rotation_model step %0d: got hex=%h act=%0d shown=%b want hex=%h act=%0d shown=%b",
                 s, hex_byte, active_src, src_shown, exp_hex, exp_act, exp_shown);
      end
      if (src_shown !== 4'b0000) begin
        total++;
        if (active_src !== 3'(grants % 4) || hex_byte !== 13'h0A0 + 13'(grants % 4) || src_shown !== (4'b0001 << (grants % 4))) begin
          bad++;
          $display("FAIL rotation_order grant %0d: got act=%0d hex=%h shown=%b want act=%0d hex=%h",
                   grants, active_src, hex_byte, src_shown, grants % 4, 13'h0A0 + 13'(grants % 4));
        end
        grants++;
      end
    end
    total++;
    if (grants !== 5) begin
      bad++;
      $display("FAIL rotation_count: got %0d grants want 5", grants);
    end
  endtask

  task automatic test_single();
    int pulses = 0;
    do_reset();
    load_a0_data();
    src_valid = 4'b0100;
    for (int s = 0; s < 12; s++) begin
      step();
      total++;
      if ({hex_byte, active_src, display_blank, src_shown} !== {exp_hex, exp_act, exp_blank, exp_shown} || active_src !== 3'd2) begin
        bad++;
        $display("FAIL single step %0d: got act=%0d shown=%b want act=2 model_shown=%b", s, active_src, src_shown, exp_shown);
      end
      if (src_shown[2]) pulses++;
    end
    total++;
    if (pulses !== 3) begin
      bad++;
      $display("FAIL single_pulses: got %0d want 3", pulses);
    end
    src_data[26 +: 13] = 13'h1FFF;
    step();
    total++;
    if (hex_byte !== 13'h1FFF) begin
      bad++;
      $display("FAIL single_data: got hex=%h want 1fff", hex_byte);
    end
  endtask

  task automatic test_urgent_preempt();
    logic [3:0] urg_pat [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic [2:0] act_pat [6] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2};
    do_reset();
    load_a0_data();
    src_valid = 4'b1111;
    repeat (5) step();
    total++;
    if (active_src !== 3'd1) begin
      bad++;
      $display("FAIL urgent_setup: got act=%0d want 1", active_src);
    end
    for (int i = 0; i < 6; i++) begin
      src_urgent = urg_pat[i];
      step();
      total++;
      if (active_src !== act_pat[i] || {hex_byte, active_src, display_blank, src_shown} !== {exp_hex, exp_act, exp_blank, exp_shown}) begin
        bad++;
        $display("FAIL urgent_hold step %0d: got act=%0d shown=%b want act=%0d shown=%b",
                 i, active_src, src_shown, act_pat[i], exp_shown);
      end
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    load_a0_data();
    src_valid = 4'b0001;
    step();
    step();
    src_valid = 4'b1000;
    step();
    total++;
    if (active_src !== 3'd3 || hex_byte !== 13'h0A3 || src_shown !== 4'b1000) begin
      bad++;
      $display("FAIL drop_switch: got act=%0d hex=%h shown=%b want act=3 hex=00a3 shown=1000", active_src, hex_byte, src_shown);
    end
    src_valid = 4'b0000;
    step();
    total++;
    if (display_blank !== 1'b1 || hex_byte !== 13'h0000 || active_src !== 3'd0) begin
      bad++;
      $display("FAIL drop_idle: got blank=%b hex=%h act=%0d want blank=1 hex=0000 act=0", display_blank, hex_byte, active_src);
    end
  endtask

  task automatic test_urgent_nesting();
    logic [3:0] urg_pat [4] = '{4'b1000, 4'b1010, 4'b1110, 4'b1110};
    logic [2:0] act_pat [4] = '{3'd3, 3'd1, 3'd1, 3'd1};
    do_reset();
    load_a0_data();
    src_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      src_urgent = urg_pat[i];
      step();
      total++;
      if (active_src !== act_pat[i] || src_shown !== exp_shown || hex_byte !== exp_hex) begin
        bad++;
        $display("FAIL urgent_nest step %0d: got act=%0d shown=%b want act=%0d shown=%b",
                 i, active_src, src_shown, act_pat[i], exp_shown);
      end
    end
    src_urgent = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_a0_data();
    src_valid = 4'b1111;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (hex_byte !== 13'h0000 || display_blank !== 1'b1 || active_src !== 3'd0 || src_shown !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid: got hex=%h act=%0d blank=%b shown=%b want 0000/0/1/0000",
               hex_byte, active_src, display_blank, src_shown);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int s = 0; s < 600; s++) begin
      if ($urandom_range(0, 3) == 0) src_valid = 4'($urandom);
      if ($urandom_range(0, 5) == 0) src_urgent = 4'($urandom & $urandom);
      if ($urandom_range(0, 2) == 0) src_data = 52'({$urandom, $urandom});
      rst = ($urandom_range(0, 80) == 0);
      step();
      total++;
      if ({hex_byte, active_src, display_blank, src_shown} !== {exp_hex, exp_act, exp_blank, exp_shown}) begin
        bad++;
        $display("FAIL random step %0d: got hex=%h act=%0d blank=%b shown=%b want hex=%h act=%0d blank=%b shown=%b",
                 s, hex_byte, active_src, display_blank, src_shown, exp_hex, exp_act, exp_blank, exp_shown);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src_valid = '0; src_urgent = '0; src_data = '0;
    m_mode = 0; m_owner = 0; m_rr = 0; m_dwell = 0; m_hold = 0;
    test_reset();
    test_rotation();
    test_single();
    test_urgent_preempt();
    test_owner_drop();
    test_urgent_nesting();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
